// File: rtl/gpio_expander_regs.sv
// gpio_expander_regs: parametrised register bank for the I2C GPIO-expander model.
// There are NUM_PORTS 8-bit ports. Each port has four registers:
// Input, Output, Polarity and Config (TCA9539-compatible map when NUM_PORTS=2).
// Optional interrupt logic is enabled by defining the macro GPIO_REGS_INT_EN.
// That logic is the settle FSM, the per-port snapshots and the int_n generator.
// Without the macro, int_n is tied high.
module gpio_expander_regs #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [7:0]             dataIn,
  input  logic                   writeEn,
  input  logic                   rdEn,
  output logic [7:0]             dataOut,
  input  logic [8*NUM_PORTS-1:0] gpio_in,
  output logic [8*NUM_PORTS-1:0] gpio_out,
  output logic [8*NUM_PORTS-1:0] gpio_oe,
  output logic                   int_n
);

  localparam int W = 8 * NUM_PORTS;

  logic [W-1:0] syncStage1;
  logic [W-1:0] syncIn;
  logic [W-1:0] outputReg;
  logic [W-1:0] polarityReg;
  logic [W-1:0] configReg;
  logic [7:0]   readData;
  int           addrInt;

  assign addrInt  = int'(addr);
  assign gpio_out = outputReg;
  assign gpio_oe  = ~configReg;

  // Two-flop synchroniser for the asynchronous pin inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncStage1 <= '0;
      syncIn     <= '0;
    end else begin
      syncStage1 <= gpio_in;
      syncIn     <= syncStage1;
    end
  end

  // Writable registers; Input addresses and out-of-range addresses ignore writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outputReg   <= '1;
      polarityReg <= '0;
      configReg   <= '1;
    end else if (writeEn) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (addrInt == NUM_PORTS + p)     outputReg[8*p +: 8]   <= dataIn;
        if (addrInt == 2 * NUM_PORTS + p) polarityReg[8*p +: 8] <= dataIn;
        if (addrInt == 3 * NUM_PORTS + p) configReg[8*p +: 8]   <= dataIn;
      end
    end
  end

  // Read multiplexer; unmapped addresses return zero
  always_comb begin
    readData = 8'h00;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (addrInt == p)                 readData = syncIn[8*p +: 8] ^ polarityReg[8*p +: 8];
      if (addrInt == NUM_PORTS + p)     readData = outputReg[8*p +: 8];
      if (addrInt == 2 * NUM_PORTS + p) readData = polarityReg[8*p +: 8];
      if (addrInt == 3 * NUM_PORTS + p) readData = configReg[8*p +: 8];
    end
  end

  // Read data is registered every cycle from the current address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dataOut <= 8'h00;
    else        dataOut <= readData;
  end

`ifdef GPIO_REGS_INT_EN
  typedef enum logic [1:0] {SETTLE0, SETTLE1, SETTLE2, ARMED} settleState_t;

  settleState_t state;
  settleState_t nextState;
  logic         armed;
  logic [W-1:0] snapshot;
  logic         pend;
  logic         intReg;

  // Settle FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SETTLE0;
    else        state <= nextState;
  end

  // Settle FSM next state: walk through the settle states once, then stay armed
  always_comb begin
    nextState = state;
    case (state)
      SETTLE0: nextState = SETTLE1;
      SETTLE1: nextState = SETTLE2;
      SETTLE2: nextState = ARMED;
      ARMED:   nextState = ARMED;
      default: nextState = SETTLE0;
    endcase
  end

  // Settle FSM output: interrupt detection only runs once the synchroniser holds real pin values
  always_comb begin
    armed = (state == ARMED);
  end

  // Snapshots track the pins while settling; once armed, they reload only when that port's Input register is read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot <= '0;
    end else if (!armed) begin
      snapshot <= syncIn;
    end else if (rdEn) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (addrInt == p) snapshot[8*p +: 8] <= syncIn[8*p +: 8];
      end
    end
  end

  // Pending change on any input-configured pin; polarity plays no part
  always_comb begin
    pend = |((syncIn ^ snapshot) & configReg);
  end

  // Registered active-low interrupt, held inactive while settling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     intReg <= 1'b1;
    else if (!armed) intReg <= 1'b1;
    else             intReg <= ~pend;
  end

  assign int_n = intReg;
`else
  logic unusedRdEn;

  assign unusedRdEn = rdEn;
  assign int_n      = 1'b1;
`endif

endmodule

// File: tb/tb_gpio_expander_regs.sv
// tb_gpio_expander_regs: directed self-checking bench for gpio_expander_regs.
// It uses a two-port instance (TCA9539 map) and a four-port instance.
// Interrupt expectations follow GPIO_REGS_INT_EN: int_n is expected to stay high when it is undefined.
module tb_gpio_expander_regs;

`ifdef GPIO_REGS_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  dataIn = 8'h00;
  logic        writeEn = 1'b0;
  logic        rdEn = 1'b0;
  logic [7:0]  dataOut;
  logic [15:0] gpioIn = 16'hA55A;
  logic [15:0] gpioOut;
  logic [15:0] gpioOe;
  logic        intN;

  logic [7:0]  addr4 = 8'h00;
  logic [7:0]  dataIn4 = 8'h00;
  logic        writeEn4 = 1'b0;
  logic        rdEn4 = 1'b0;
  logic [7:0]  dataOut4;
  logic [31:0] gpioIn4 = 32'h0;
  logic [31:0] gpioOut4;
  logic [31:0] gpioOe4;
  logic        intN4;

  int checks = 0;
  int errors = 0;

  gpio_expander_regs #(.NUM_PORTS(2), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .dataIn(dataIn), .writeEn(writeEn),
    .rdEn(rdEn), .dataOut(dataOut), .gpio_in(gpioIn), .gpio_out(gpioOut),
    .gpio_oe(gpioOe), .int_n(intN)
  );

  gpio_expander_regs #(.NUM_PORTS(4), .ADDR_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .addr(addr4), .dataIn(dataIn4), .writeEn(writeEn4),
    .rdEn(rdEn4), .dataOut(dataOut4), .gpio_in(gpioIn4), .gpio_out(gpioOut4),
    .gpio_oe(gpioOe4), .int_n(intN4)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle slightly past it before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
    addr = a; dataIn = d; writeEn = 1'b1;
    tick();
    writeEn = 1'b0;
  endtask

  task automatic readReg(input logic [7:0] a, output logic [7:0] d);
    addr = a;
    tick();
    d = dataOut;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    logic [7:0] expR [6];
    logic [7:0] adrR [6];
    adrR = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd6};
    expR = '{8'h5A, 8'hA5, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    rst_n = 1'b0;
    gpioIn = 16'hA55A;
    tick(); tick();
    checks++;
    if (dataOut !== 8'h00 || gpioOut !== 16'hFFFF || gpioOe !== 16'h0000 || intN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got dataOut=%h gpio_out=%h gpio_oe=%h int_n=%b, want 00 ffff 0000 1",
               dataOut, gpioOut, gpioOe, intN);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (intN !== 1'b1) begin
        errors++;
        $display("[TB] FAIL settle_int_n cycle %0d: got %b, want 1", i, intN);
      end
    end
    for (int i = 0; i < 6; i++) begin
      readReg(adrR[i], rd);
      checks++;
      if (rd !== expR[i]) begin
        errors++;
        $display("[TB] FAIL reset_read addr %0d: got %h, want %h", adrR[i], rd, expR[i]);
      end
    end
  endtask

  task automatic test_polarity();
    writeReg(8'd4, 8'hFF);
    gpioIn[7:0] = 8'h0F;
    addr = 8'd0;
    tick(); tick();
    checks++;
    if (intN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pin_int_early: got %b, want 1", intN);
    end
    tick();
    checks++;
    if (dataOut !== 8'hF0) begin
      errors++;
      $display("[TB] FAIL polarity_read: got %h, want f0", dataOut);
    end
    checks++;
    if (intN !== ~INT_EN) begin
      errors++;
      $display("[TB] FAIL port0_int: got %b, want %b", intN, ~INT_EN);
    end
    rdEn = 1'b1; addr = 8'd0;
    tick();
    rdEn = 1'b0;
    tick();
    checks++;
    if (intN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL port0_clear: got %b, want 1", intN);
    end
  endtask

  task automatic test_interrupt();
    gpioIn[8] = 1'b0;
    tick(); tick();
    checks++;
    if (intN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL port1_int_early: got %b, want 1", intN);
    end
    tick();
    checks++;
    if (intN !== ~INT_EN) begin
      errors++;
      $display("[TB] FAIL port1_int: got %b, want %b", intN, ~INT_EN);
    end
    rdEn = 1'b1; addr = 8'd1;
    tick();
    rdEn = 1'b0;
    tick();
    checks++;
    if (intN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL port1_clear: got %b, want 1", intN);
    end
    gpioIn[8] = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (intN !== ~INT_EN) begin
      errors++;
      $display("[TB] FAIL port1_reassert: got %b, want %b", intN, ~INT_EN);
    end
    gpioIn[8] = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (intN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pin_return_clear: got %b, want 1", intN);
    end
  endtask

  task automatic test_config_mask();
    writeReg(8'd6, 8'h00);
    checks++;
    if (gpioOe !== 16'h00FF) begin
      errors++;
      $display("[TB] FAIL config_oe: got %h, want 00ff", gpioOe);
    end
    gpioIn[3:0] = 4'h0;
    tick(); tick(); tick(); tick();
    checks++;
    if (intN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL masked_int: got %b, want 1", intN);
    end
    writeReg(8'd6, 8'hFF);
    tick();
    checks++;
    if (intN !== ~INT_EN) begin
      errors++;
      $display("[TB] FAIL unmask_int: got %b, want %b", intN, ~INT_EN);
    end
    checks++;
    if (gpioOe !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL config_oe_restore: got %h, want 0000", gpioOe);
    end
    rdEn = 1'b1; addr = 8'd0;
    tick();
    rdEn = 1'b0;
    tick();
    checks++;
    if (intN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unmask_clear: got %b, want 1", intN);
    end
  endtask

  task automatic test_output();
    logic [7:0] rd;
    writeReg(8'd2, 8'h12);
    writeReg(8'd3, 8'h34);
    checks++;
    if (gpioOut !== 16'h3412) begin
      errors++;
      $display("[TB] FAIL output_pins: got %h, want 3412", gpioOut);
    end
    readReg(8'd3, rd);
    checks++;
    if (rd !== 8'h34) begin
      errors++;
      $display("[TB] FAIL output_readback: got %h, want 34", rd);
    end
    writeReg(8'd0, 8'h77);
    readReg(8'd0, rd);
    checks++;
    if (rd !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL input_write_ignored: got %h, want ff", rd);
    end
    writeReg(8'd8, 8'h55);
    readReg(8'd8, rd);
    checks++;
    if (rd !== 8'h00 || gpioOut !== 16'h3412 || gpioOe !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL out_of_range: got rd=%h gpio_out=%h gpio_oe=%h, want 00 3412 0000", rd, gpioOut, gpioOe);
    end
  endtask

  task automatic test_ports4();
    addr4 = 8'd7; dataIn4 = 8'h3C; writeEn4 = 1'b1;
    tick();
    writeEn4 = 1'b0;
    checks++;
    if (gpioOut4 !== 32'h3CFFFFFF || gpioOe4 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL ports4_output: got gpio_out=%h gpio_oe=%h, want 3cffffff 00000000", gpioOut4, gpioOe4);
    end
    addr4 = 8'd16;
    tick();
    checks++;
    if (dataOut4 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL ports4_addr16: got %h, want 00", dataOut4);
    end
    addr4 = 8'd15;
    tick();
    checks++;
    if (dataOut4 !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL ports4_config3: got %h, want ff", dataOut4);
    end
  endtask

  task automatic test_reset_mid();
    gpioIn[0] = 1'b1;
    addr = 8'd2;
    tick(); tick(); tick();
    checks++;
    if (intN !== ~INT_EN || gpioOut[7:0] !== 8'h12) begin
      errors++;
      $display("[TB] FAIL pre_reset: got int_n=%b out0=%h, want %b 12", intN, gpioOut[7:0], ~INT_EN);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (intN !== 1'b1 || gpioOut !== 16'hFFFF || gpioOe !== 16'h0000 || dataOut !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset: got int_n=%b gpio_out=%h gpio_oe=%h dataOut=%h, want 1 ffff 0000 00",
               intN, gpioOut, gpioOe, dataOut);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Scenario sequence; the whole run is a fixed, short number of cycles
  initial begin
    test_reset();
    test_polarity();
    test_interrupt();
    test_config_mask();
    test_output();
    test_ports4();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
